// File: rtl/nn_result_reader_if.sv
// Signal bundle between the result reader, the I/O RAM read port and the
// display/host consumer of the classification result.
interface nn_result_reader_if #(
    parameter int N_OUT  = 10,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
);
    logic                            Start;
    logic                            Busy;
    logic                            Rd_en;
    logic [ADDR_W-1:0]               Address;
    logic [DATA_W-1:0]               Q;
    logic                            Valid;
    logic                            Ack;
    logic [3:0]                      Digit;
    logic [DATA_W-1:0]               Score;
    logic [N_OUT-1:0][DATA_W-1:0]    Scores;

    modport master (
        input  Start, Q, Ack,
        output Busy, Rd_en, Address, Valid, Digit, Score, Scores
    );

    modport slave (
        output Start, Q, Ack,
        input  Busy, Rd_en, Address, Valid, Digit, Score, Scores
    );
endinterface

// File: rtl/nn_result_reader.sv
// Sweeps the output-layer activations out of the I/O RAM one word per cycle
// and runs a signed argmax over them to produce the classified digit.
module nn_result_reader #(
    parameter int                N_OUT     = 10,
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 10,
    parameter int                RD_LAT    = 2,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input logic               Clk,
    input logic               Reset_n,
    nn_result_reader_if.master bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam logic [4:0] LAST_IDX = 5'(N_OUT - 1);
    localparam logic [4:0] N_CNT    = 5'(N_OUT);

    state_t                        state, state_nxt;
    logic [4:0]                    issue_cnt;
    logic [4:0]                    ret_cnt;
    logic [RD_LAT-1:0]             vld_p;
    logic signed [DATA_W-1:0]      max_p;
    logic [3:0]                    digit_p;
    logic [N_OUT-1:0][DATA_W-1:0]  scores_p;
    logic signed [DATA_W-1:0]      q_s;
    logic                          rd_en;
    logic [ADDR_W-1:0]             rd_addr;
    logic                          ret_vld;

    function automatic logic gt_signed(input logic signed [DATA_W-1:0] a,
                                       input logic signed [DATA_W-1:0] b);
        return a > b;
    endfunction

    assign q_s     = bus.Q;
    assign ret_vld = vld_p[RD_LAT-1];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (bus.Start)            state_nxt = ISSUE;
            ISSUE: if (issue_cnt == LAST_IDX) state_nxt = DRAIN;
            DRAIN: if (ret_cnt == N_CNT)      state_nxt = DONE;
            DONE:  if (bus.Ack)              state_nxt = IDLE;
            default:                         state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        rd_en   = (state == ISSUE);
        rd_addr = '0;
        if (rd_en) rd_addr = BASE_ADDR + ADDR_W'(issue_cnt);
    end

    // Issue stage: counters and the tag pipe that mirrors the RAM read latency
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            issue_cnt <= '0;
            ret_cnt   <= '0;
            vld_p     <= '0;
        end else begin
            vld_p[0] <= rd_en;
            for (int j = 1; j < RD_LAT; j++) vld_p[j] <= vld_p[j-1];
            if (state == IDLE && bus.Start) begin
                issue_cnt <= '0;
                ret_cnt   <= '0;
            end else begin
                if (state == ISSUE) issue_cnt <= issue_cnt + 5'd1;
                if (ret_vld)        ret_cnt   <= ret_cnt + 5'd1;
            end
        end
    end

    // Return stage: capture each tagged word and update the running argmax.
    // The first return of a sweep always overwrites, so the previous result
    // stays visible until then.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            max_p    <= '0;
            digit_p  <= '0;
            scores_p <= '0;
        end else if (ret_vld) begin
            for (int k = 0; k < N_OUT; k++) begin
                if (ret_cnt == 5'(k)) scores_p[k] <= bus.Q;
            end
            if (ret_cnt == 5'd0 || gt_signed(q_s, max_p)) begin
                max_p   <= q_s;
                digit_p <= ret_cnt[3:0];
            end
        end
    end

    assign bus.Rd_en   = rd_en;
    assign bus.Address = rd_addr;
    assign bus.Busy    = (state == ISSUE) || (state == DRAIN);
    assign bus.Valid   = (state == DONE);
    assign bus.Digit   = digit_p;
    assign bus.Score   = max_p;
    assign bus.Scores  = scores_p;

endmodule

// File: tb/tb_nn_result_reader.sv
// Scoreboard bench for nn_result_reader: a default instance (10 outputs,
// latency 2) and a corner instance (16 outputs, latency 4, base 1000).
module tb_nn_result_reader;

    localparam int         N_A    = 10;
    localparam int         LAT_A  = 2;
    localparam int         N_B    = 16;
    localparam int         LAT_B  = 4;
    localparam logic [9:0] BASE_A = 10'd0;
    localparam logic [9:0] BASE_B = 10'd1000;
    localparam int         VC_A   = N_A + LAT_A + 2;
    localparam int         VC_B   = N_B + LAT_B + 2;
    localparam logic [15:0] POISON = 16'h7FFE;

    typedef struct {
        logic [3:0]  digit;
        logic [15:0] score;
        logic [15:0] sc [16];
    } exp_t;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   rd_cnt_a = 0;
    exp_t sbq_a[$];
    exp_t sbq_b[$];
    exp_t last_a;
    exp_t last_b;

    logic [15:0] mem [0:1023];
    logic [15:0] qp_a [LAT_A];
    logic [15:0] qp_b [LAT_B];
    logic [15:0] v [16];

    always #5 Clk = ~Clk;

    nn_result_reader_if #(.N_OUT(N_A), .DATA_W(16), .ADDR_W(10)) ba();
    nn_result_reader_if #(.N_OUT(N_B), .DATA_W(16), .ADDR_W(10)) bb();

    nn_result_reader #(.N_OUT(N_A), .DATA_W(16), .ADDR_W(10), .RD_LAT(LAT_A),
                       .BASE_ADDR(BASE_A))
        dut_a (.Clk(Clk), .Reset_n(Reset_n), .bus(ba));

    nn_result_reader #(.N_OUT(N_B), .DATA_W(16), .ADDR_W(10), .RD_LAT(LAT_B),
                       .BASE_ADDR(BASE_B))
        dut_b (.Clk(Clk), .Reset_n(Reset_n), .bus(bb));

    // RAM models: words not tied to a read come back as a large poison value
    always @(posedge Clk) begin
        qp_a[0] <= ba.Rd_en ? mem[ba.Address] : POISON;
        for (int j = 1; j < LAT_A; j++) qp_a[j] <= qp_a[j-1];
        qp_b[0] <= bb.Rd_en ? mem[bb.Address] : POISON;
        for (int j = 1; j < LAT_B; j++) qp_b[j] <= qp_b[j-1];
        if (ba.Rd_en) rd_cnt_a <= rd_cnt_a + 1;
    end
    assign ba.Q = qp_a[LAT_A-1];
    assign bb.Q = qp_b[LAT_B-1];

    function automatic exp_t model(input logic [15:0] vals [16], input int n);
        exp_t e;
        e.digit = 4'd0;
        e.score = vals[0];
        for (int i = 0; i < 16; i++) e.sc[i] = (i < n) ? vals[i] : 16'h0000;
        for (int i = 1; i < n; i++) begin
            if ($signed(vals[i]) > $signed(e.score)) begin
                e.score = vals[i];
                e.digit = 4'(i);
            end
        end
        return e;
    endfunction

    task automatic load(input logic [9:0] base, input int n, input bit to_b, input bit push);
        for (int i = 0; i < n; i++) mem[int'(base) + i] = v[i];
        if (push) begin
            if (to_b) sbq_b.push_back(model(v, n));
            else      sbq_a.push_back(model(v, n));
        end
    endtask

    task automatic start_a();
        @(posedge Clk); #1 ba.Start = 1'b1;
        @(posedge Clk); #1 ba.Start = 1'b0;
    endtask

    task automatic sweep_a(input string name, input int start_cyc);
        logic       exp_rd, exp_busy, exp_valid;
        logic [9:0] exp_addr;
        for (int c = 1; c <= VC_A; c++) begin
            if (c > 1) begin @(posedge Clk); #1; end
            ba.Start  = (c == start_cyc);
            exp_rd    = (c <= N_A);
            exp_addr  = exp_rd ? 10'(int'(BASE_A) + c - 1) : 10'd0;
            exp_busy  = (c < VC_A);
            exp_valid = (c == VC_A);
            checks++;
            if (ba.Rd_en !== exp_rd || ba.Address !== exp_addr ||
                ba.Busy !== exp_busy || ba.Valid !== exp_valid) begin
                errors++;
                $display("FAIL %s cyc%0d: rd_en=%b addr=%0d busy=%b valid=%b, expected %b %0d %b %b",
                         name, c, ba.Rd_en, ba.Address, ba.Busy, ba.Valid,
                         exp_rd, exp_addr, exp_busy, exp_valid);
            end
        end
        ba.Start = 1'b0;
    endtask

    task automatic result_a(input string name);
        checks++;
        if (sbq_a.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, got digit=%0d expected a queued result", name, ba.Digit);
        end else begin
            last_a = sbq_a.pop_front();
            if (ba.Digit !== last_a.digit || ba.Score !== last_a.score) begin
                errors++;
                $display("FAIL %s result: digit=%0d score=%h, expected %0d %h",
                         name, ba.Digit, ba.Score, last_a.digit, last_a.score);
            end
            for (int i = 0; i < N_A; i++) begin
                checks++;
                if (ba.Scores[i] !== last_a.sc[i]) begin
                    errors++;
                    $display("FAIL %s scores[%0d]: got %h, expected %h",
                             name, i, ba.Scores[i], last_a.sc[i]);
                end
            end
        end
    endtask

    task automatic ack_a(input string name);
        ba.Ack = 1'b1;
        @(posedge Clk); #1 ba.Ack = 1'b0;
        checks++;
        if (ba.Valid !== 1'b0 || ba.Busy !== 1'b0 || ba.Rd_en !== 1'b0) begin
            errors++;
            $display("FAIL %s ack: valid=%b busy=%b rd_en=%b, expected 0 0 0",
                     name, ba.Valid, ba.Busy, ba.Rd_en);
        end
    endtask

    task automatic test_reset();
        ba.Start = 1'b0; ba.Ack = 1'b0;
        bb.Start = 1'b0; bb.Ack = 1'b0;
        #12;
        checks++;
        if ({ba.Busy, ba.Rd_en, ba.Valid} !== 3'b000 || ba.Address !== 10'd0 ||
            ba.Digit !== 4'd0 || ba.Score !== 16'd0 || ba.Scores !== '0) begin
            errors++;
            $display("FAIL reset_a: busy=%b rd_en=%b valid=%b addr=%0d digit=%0d score=%h, expected all 0",
                     ba.Busy, ba.Rd_en, ba.Valid, ba.Address, ba.Digit, ba.Score);
        end
        checks++;
        if ({bb.Busy, bb.Rd_en, bb.Valid} !== 3'b000 || bb.Address !== 10'd0 ||
            bb.Digit !== 4'd0 || bb.Score !== 16'd0 || bb.Scores !== '0) begin
            errors++;
            $display("FAIL reset_b: busy=%b rd_en=%b valid=%b addr=%0d digit=%0d score=%h, expected all 0",
                     bb.Busy, bb.Rd_en, bb.Valid, bb.Address, bb.Digit, bb.Score);
        end
        @(posedge Clk); #1 Reset_n = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        checks++;
        if ({ba.Busy, ba.Rd_en, ba.Valid} !== 3'b000) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b rd_en=%b valid=%b, expected 0 0 0",
                     ba.Busy, ba.Rd_en, ba.Valid);
        end
    endtask

    task automatic test_basic();
        for (int i = 0; i < 16; i++) v[i] = 16'h0001;
        v[7] = 16'h0010;
        load(BASE_A, N_A, 1'b0, 1'b1);
        start_a();
        sweep_a("basic", 0);
        result_a("basic");
        ack_a("basic");
    endtask

    task automatic test_signed();
        for (int i = 0; i < 16; i++) v[i] = 16'(-(i + 1));
        v[3] = 16'hFFFF;
        load(BASE_A, N_A, 1'b0, 1'b1);
        start_a();
        sweep_a("signed_neg", 0);
        result_a("signed_neg");
        ack_a("signed_neg");
        for (int i = 0; i < 16; i++) v[i] = 16'(-(i + 1));
        v[9] = 16'h7FFF;
        v[2] = 16'h8000;
        load(BASE_A, N_A, 1'b0, 1'b1);
        start_a();
        sweep_a("signed_ext", 0);
        result_a("signed_ext");
        ack_a("signed_ext");
    endtask

    task automatic test_tie_hold();
        for (int i = 0; i < 16; i++) v[i] = 16'h0001;
        v[2] = 16'h0100;
        v[5] = 16'h0100;
        load(BASE_A, N_A, 1'b0, 1'b1);
        start_a();
        sweep_a("tie", 0);
        result_a("tie");
        for (int c = 0; c < 20; c++) begin
            @(posedge Clk); #1;
            checks++;
            if (ba.Valid !== 1'b1 || ba.Busy !== 1'b0 || ba.Rd_en !== 1'b0 ||
                ba.Digit !== last_a.digit || ba.Score !== last_a.score ||
                ba.Scores[5] !== last_a.sc[5]) begin
                errors++;
                $display("FAIL hold cyc%0d: valid=%b busy=%b rd_en=%b digit=%0d score=%h, expected 1 0 0 %0d %h",
                         c, ba.Valid, ba.Busy, ba.Rd_en, ba.Digit, ba.Score,
                         last_a.digit, last_a.score);
            end
        end
        ack_a("tie");
    endtask

    task automatic test_ignored_controls();
        int rd_before;
        for (int i = 0; i < 16; i++) v[i] = 16'h0010;
        v[4] = 16'h0200;
        load(BASE_A, N_A, 1'b0, 1'b1);
        rd_before = rd_cnt_a;
        start_a();
        sweep_a("ignored", 4);
        result_a("ignored");
        ba.Start = 1'b1; ba.Ack = 1'b1;
        @(posedge Clk); #1 ba.Start = 1'b0; ba.Ack = 1'b0;
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (ba.Busy !== 1'b0 || ba.Rd_en !== 1'b0 || ba.Valid !== 1'b0) begin
                errors++;
                $display("FAIL start_with_ack cyc%0d: busy=%b rd_en=%b valid=%b, expected 0 0 0",
                         c, ba.Busy, ba.Rd_en, ba.Valid);
            end
            @(posedge Clk); #1;
        end
        checks++;
        if (rd_cnt_a - rd_before !== N_A) begin
            errors++;
            $display("FAIL read_count: got %0d reads, expected %0d", rd_cnt_a - rd_before, N_A);
        end
        ba.Ack = 1'b1;
        @(posedge Clk); #1 ba.Ack = 1'b0;
        @(posedge Clk); #1;
        checks++;
        if (ba.Busy !== 1'b0 || ba.Valid !== 1'b0 || ba.Rd_en !== 1'b0 ||
            ba.Digit !== last_a.digit || ba.Score !== last_a.score) begin
            errors++;
            $display("FAIL ack_in_idle: busy=%b valid=%b rd_en=%b digit=%0d score=%h, expected 0 0 0 %0d %h",
                     ba.Busy, ba.Valid, ba.Rd_en, ba.Digit, ba.Score, last_a.digit, last_a.score);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 16; i++) v[i] = 16'h0020;
        v[8] = 16'h0300;
        load(BASE_A, N_A, 1'b0, 1'b0);
        start_a();
        repeat (5) @(posedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        checks++;
        if ({ba.Busy, ba.Rd_en, ba.Valid} !== 3'b000 || ba.Address !== 10'd0 ||
            ba.Digit !== 4'd0 || ba.Score !== 16'd0 || ba.Scores !== '0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b rd_en=%b valid=%b addr=%0d digit=%0d score=%h, expected all 0",
                     ba.Busy, ba.Rd_en, ba.Valid, ba.Address, ba.Digit, ba.Score);
        end
        @(posedge Clk); #1 Reset_n = 1'b1;
        for (int i = 0; i < 16; i++) v[i] = 16'(i);
        v[1] = 16'h0400;
        load(BASE_A, N_A, 1'b0, 1'b1);
        start_a();
        sweep_a("after_reset", 0);
        result_a("after_reset");
        ack_a("after_reset");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) v[i] = 16'h0003;
        v[6] = 16'h0033;
        load(BASE_A, N_A, 1'b0, 1'b1);
        start_a();
        sweep_a("b2b_first", 0);
        result_a("b2b_first");
        for (int i = 0; i < 16; i++) v[i] = 16'(-(3 * i + 2));
        v[0] = 16'h0050;
        load(BASE_A, N_A, 1'b0, 1'b1);
        ba.Ack = 1'b1;
        @(posedge Clk); #1 ba.Ack = 1'b0; ba.Start = 1'b1;
        checks++;
        if (ba.Valid !== 1'b0 || ba.Busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap: valid=%b busy=%b, expected 0 0", ba.Valid, ba.Busy);
        end
        @(posedge Clk); #1 ba.Start = 1'b0;
        sweep_a("b2b_second", 0);
        result_a("b2b_second");
        ack_a("b2b_second");
    endtask

    task automatic test_corner();
        logic       exp_rd, exp_busy, exp_valid;
        logic [9:0] exp_addr;
        for (int i = 0; i < 16; i++) v[i] = 16'(i * 16 - 100);
        v[15] = 16'h0500;
        load(BASE_B, N_B, 1'b1, 1'b1);
        @(posedge Clk); #1 bb.Start = 1'b1;
        @(posedge Clk); #1 bb.Start = 1'b0;
        for (int c = 1; c <= VC_B; c++) begin
            if (c > 1) begin @(posedge Clk); #1; end
            exp_rd    = (c <= N_B);
            exp_addr  = exp_rd ? 10'(int'(BASE_B) + c - 1) : 10'd0;
            exp_busy  = (c < VC_B);
            exp_valid = (c == VC_B);
            checks++;
            if (bb.Rd_en !== exp_rd || bb.Address !== exp_addr ||
                bb.Busy !== exp_busy || bb.Valid !== exp_valid) begin
                errors++;
                $display("FAIL corner cyc%0d: rd_en=%b addr=%0d busy=%b valid=%b, expected %b %0d %b %b",
                         c, bb.Rd_en, bb.Address, bb.Busy, bb.Valid,
                         exp_rd, exp_addr, exp_busy, exp_valid);
            end
        end
        checks++;
        if (sbq_b.size() == 0) begin
            errors++;
            $display("FAIL corner: scoreboard empty, got digit=%0d expected a queued result", bb.Digit);
        end else begin
            last_b = sbq_b.pop_front();
            if (bb.Digit !== last_b.digit || bb.Score !== last_b.score) begin
                errors++;
                $display("FAIL corner result: digit=%0d score=%h, expected %0d %h",
                         bb.Digit, bb.Score, last_b.digit, last_b.score);
            end
            for (int i = 0; i < N_B; i++) begin
                checks++;
                if (bb.Scores[i] !== last_b.sc[i]) begin
                    errors++;
                    $display("FAIL corner scores[%0d]: got %h, expected %h",
                             i, bb.Scores[i], last_b.sc[i]);
                end
            end
        end
        bb.Ack = 1'b1;
        @(posedge Clk); #1 bb.Ack = 1'b0;
        checks++;
        if (bb.Valid !== 1'b0 || bb.Busy !== 1'b0) begin
            errors++;
            $display("FAIL corner ack: valid=%b busy=%b, expected 0 0", bb.Valid, bb.Busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_tie_hold();
        test_ignored_controls();
        test_reset_mid();
        test_back_to_back();
        test_corner();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

endmodule
